// File: rtl/core_pkg.sv
// Shared RV64 core definitions: opcode constants, immediate-type codes,
// the canonical NOP and the fetch FSM state encoding.
package core_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;

    localparam logic [2:0] IT_I    = 3'd0;
    localparam logic [2:0] IT_S    = 3'd1;
    localparam logic [2:0] IT_B    = 3'd2;
    localparam logic [2:0] IT_U    = 3'd3;
    localparam logic [2:0] IT_J    = 3'd4;
    localparam logic [2:0] IT_NONE = 3'd7;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_type_dec.sv
// Combinational opcode -> immediate-type classifier feeding the immediate
// generator downstream of the IF/ID register.
module inst_type_dec
    import core_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [2:0] inst_type_o
);

    always_comb begin
        inst_type_o = IT_NONE;
        case (opcode_i)
            OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR: inst_type_o = IT_I;
            OPC_STORE:                                  inst_type_o = IT_S;
            OPC_BRANCH:                                 inst_type_o = IT_B;
            OPC_LUI, OPC_AUIPC:                         inst_type_o = IT_U;
            OPC_JAL:                                    inst_type_o = IT_J;
            default:                                    inst_type_o = IT_NONE;
        endcase
    end

endmodule

// File: rtl/if_stage.sv
// RV64 instruction-fetch stage: PC, single outstanding imem request, IF/ID register.
// Optional performance counters are built when IF_PERF_EN is defined.
module if_stage
    import core_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
)
(
    input  logic        in_clk,
    input  logic        in_rst,
    output logic        out_imem_req,
    output logic [63:0] out_imem_addr,
    input  logic        in_imem_rvalid,
    input  logic [31:0] in_imem_rdata,
    input  logic        in_redirect,
    input  logic [63:0] in_redirect_pc,
    output logic        out_valid,
    input  logic        in_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
`ifdef IF_PERF_EN
    output logic [31:0] out_perf_fetched,
    output logic [31:0] out_perf_stall,
`endif
    output logic [2:0]  out_inst_type
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  drop_addr_q, drop_addr_d;
    logic         valid_q, valid_d;
    logic [31:0]  inst_q, inst_d;
    logic [63:0]  inst_pc_q, inst_pc_d;
    logic [2:0]   type_q, type_d;
    logic [2:0]   dec_type;
    logic         req;
    logic         complete;

    inst_type_dec u_dec (
        .opcode_i    (in_imem_rdata[6:0]),
        .inst_type_o (dec_type)
    );

    always_comb begin
        req         = 1'b0;
        complete    = 1'b0;
        state_d     = state_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        type_d      = type_q;
        // Outside DROP the abandoned-request address simply shadows the PC.
        drop_addr_d = (state_q == ST_DROP) ? drop_addr_q : pc_q;

        case (state_q)
            ST_IDLE: begin
                req = (!valid_q || in_ready) && !in_redirect;
                if (req) begin
                    if (in_imem_rvalid) complete = 1'b1;
                    else                state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                req = 1'b1;
                if (in_redirect) begin
                    state_d = in_imem_rvalid ? ST_IDLE : ST_DROP;
                end else if (in_imem_rvalid) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DROP: begin
                req = 1'b1;
                if (in_imem_rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (complete) begin
            inst_d    = in_imem_rdata;
            inst_pc_d = pc_q;
            type_d    = dec_type;
            valid_d   = 1'b1;
            pc_d      = pc_q + 64'd4;
        end else if (in_ready) begin
            valid_d = 1'b0;
        end

        if (in_redirect) begin
            pc_d    = in_redirect_pc & ~64'd3;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            valid_q     <= 1'b0;
            inst_q      <= NOP_INST;
            inst_pc_q   <= 64'd0;
            type_q      <= IT_I;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            valid_q     <= valid_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            type_q      <= type_d;
        end
    end

    // Gating by reset lets the memory see the request drop the moment reset hits.
    assign out_imem_req  = req && !in_rst;
    assign out_imem_addr = (state_q == ST_DROP) ? drop_addr_q : pc_q;
    assign out_valid     = valid_q;
    assign out_inst      = inst_q;
    assign out_pc        = inst_pc_q;
    assign out_inst_type = type_q;

`ifdef IF_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] stall_q;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            fetched_q <= 32'd0;
            stall_q   <= 32'd0;
        end else begin
            if (complete && (fetched_q != 32'hFFFF_FFFF))
                fetched_q <= fetched_q + 32'd1;
            if (valid_q && !in_ready && (stall_q != 32'hFFFF_FFFF))
                stall_q <= stall_q + 32'd1;
        end
    end

    assign out_perf_fetched = fetched_q;
    assign out_perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a latency-configurable imem model.
// Perf-counter checks are compiled in when IF_PERF_EN is defined.
module tb_if_stage;

    logic        clk;
    logic        in_rst;
    logic        out_imem_req;
    logic [63:0] out_imem_addr;
    logic        in_imem_rvalid;
    logic [31:0] in_imem_rdata;
    logic        in_redirect;
    logic [63:0] in_redirect_pc;
    logic        out_valid;
    logic        in_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic [2:0]  out_inst_type;
`ifdef IF_PERF_EN
    logic [31:0] out_perf_fetched;
    logic [31:0] out_perf_stall;
`endif

    int total = 0;
    int bad   = 0;
    int mem_lat  = 0;
    int wait_cnt = 0;
    logic [31:0] data_q[$];

    if_stage #(.RESET_PC(64'h1000)) dut (
        .in_clk         (clk),
        .in_rst         (in_rst),
        .out_imem_req   (out_imem_req),
        .out_imem_addr  (out_imem_addr),
        .in_imem_rvalid (in_imem_rvalid),
        .in_imem_rdata  (in_imem_rdata),
        .in_redirect    (in_redirect),
        .in_redirect_pc (in_redirect_pc),
        .out_valid      (out_valid),
        .in_ready       (in_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
`ifdef IF_PERF_EN
        .out_perf_fetched (out_perf_fetched),
        .out_perf_stall   (out_perf_stall),
`endif
        .out_inst_type  (out_inst_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents when no explicit word is queued: an OP-IMM tagged by address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[31:7], 7'b0010011};
    endfunction

    // One clock cycle: drive inputs after negedge, answer the request, leave
    // the caller 2 time units later to sample combinational and registered outputs.
    task automatic tick(input logic rdy, input logic redir, input logic [63:0] rpc,
                        input logic force_rv);
        @(negedge clk);
        in_ready       = rdy;
        in_redirect    = redir;
        in_redirect_pc = rpc;
        in_imem_rvalid = 1'b0;
        #1;
        if (out_imem_req) begin
            if (wait_cnt >= mem_lat) begin
                in_imem_rvalid = 1'b1;
                if (data_q.size() > 0) in_imem_rdata = data_q.pop_front();
                else                   in_imem_rdata = mem_word(out_imem_addr);
                wait_cnt = 0;
                $display("t=%0t resp addr=%h data=%h redir=%b", $time, out_imem_addr,
                         in_imem_rdata, redir);
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (force_rv) begin
                in_imem_rvalid = 1'b1;
                in_imem_rdata  = 32'hDEAD_BEEF;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        in_rst = 1'b1; in_ready = 1'b0; in_redirect = 1'b0; in_redirect_pc = '0;
        in_imem_rvalid = 1'b0; in_imem_rdata = '0;
        repeat (2) @(negedge clk);
        total++; if (out_imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", out_imem_req); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_inst !== 32'h0000_0013) begin bad++; $display("FAIL reset_inst got=%h exp=00000013", out_inst); end
        total++; if (out_pc !== 64'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", out_pc); end
        total++; if (out_inst_type !== 3'd0) begin bad++; $display("FAIL reset_type got=%0d exp=0", out_inst_type); end
        total++; if (out_imem_addr !== 64'h1000) begin bad++; $display("FAIL reset_addr got=%h exp=1000", out_imem_addr); end
        @(posedge clk); #1;
        in_rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_stream();
        logic [2:0]  exp_type[3] = '{3'd3, 3'd4, 3'd7};
        logic [31:0] exp_inst[3] = '{32'h0000_0537, 32'h0000_006F, 32'h0000_0033};
        mem_lat = 0;
        data_q.push_back(32'h0000_0537);
        data_q.push_back(32'h0000_006F);
        data_q.push_back(32'h0000_0033);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 64'd0, 1'b0);
            total++; if (out_imem_addr !== 64'h1000 + 64'(4 * i)) begin bad++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, out_imem_addr, 64'h1000 + 64'(4 * i)); end
            total++; if (out_imem_req !== 1'b1) begin bad++; $display("FAIL stream_req[%0d] got=%b exp=1", i, out_imem_req); end
            if (i == 0) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_valid0 got=%b exp=0", out_valid); end
            end else begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
                total++; if (out_pc !== 64'h1000 + 64'(4 * (i - 1))) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, out_pc, 64'h1000 + 64'(4 * (i - 1))); end
                total++; if (out_inst_type !== exp_type[i-1]) begin bad++; $display("FAIL stream_type[%0d] got=%0d exp=%0d", i, out_inst_type, exp_type[i-1]); end
                total++; if (out_inst !== exp_inst[i-1]) begin bad++; $display("FAIL stream_inst[%0d] got=%h exp=%h", i, out_inst, exp_inst[i-1]); end
            end
        end
    endtask

    task automatic test_stall();
        mem_lat = 3;
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        total++; if (out_imem_addr !== 64'h1010) begin bad++; $display("FAIL stall_addr0 got=%h exp=1010", out_imem_addr); end
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_wait_valid got=%b exp=0", out_valid); end
        total++; if (out_imem_req !== 1'b1) begin bad++; $display("FAIL stall_wait_req got=%b exp=1", out_imem_req); end
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        total++; if (in_imem_rvalid !== 1'b1) begin bad++; $display("FAIL stall_latency got=%b exp=1", in_imem_rvalid); end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 64'd0, 1'b0);
            total++; if (out_imem_req !== 1'b0) begin bad++; $display("FAIL stall_req[%0d] got=%b exp=0", i, out_imem_req); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if (out_pc !== 64'h1010) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=1010", i, out_pc); end
            total++; if (out_inst !== mem_word(64'h1010)) begin bad++; $display("FAIL stall_inst[%0d] got=%h exp=%h", i, out_inst, mem_word(64'h1010)); end
        end
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        total++; if (out_imem_req !== 1'b1) begin bad++; $display("FAIL stall_resume_req got=%b exp=1", out_imem_req); end
        total++; if (out_imem_addr !== 64'h1014) begin bad++; $display("FAIL stall_resume_addr got=%h exp=1014", out_imem_addr); end
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain_valid got=%b exp=0", out_valid); end
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        total++; if (out_pc !== 64'h1014 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_next_pc got=%h/%b exp=1014/1", out_pc, out_valid); end
        total++; if (out_imem_addr !== 64'h1018) begin bad++; $display("FAIL stall_next_addr got=%h exp=1018", out_imem_addr); end
    endtask

    task automatic test_redirect_wait();
        tick(1'b1, 1'b1, 64'h2003, 1'b0);
        total++; if (out_imem_addr !== 64'h1018) begin bad++; $display("FAIL rw_addr_redir got=%h exp=1018", out_imem_addr); end
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        total++; if (out_imem_addr !== 64'h1018) begin bad++; $display("FAIL rw_drop_addr got=%h exp=1018", out_imem_addr); end
        total++; if (out_imem_req !== 1'b1) begin bad++; $display("FAIL rw_drop_req got=%b exp=1", out_imem_req); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rw_drop_valid got=%b exp=0", out_valid); end
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        total++; if (in_imem_rvalid !== 1'b1 || out_imem_addr !== 64'h1018) begin bad++; $display("FAIL rw_old_resp got=%b/%h exp=1/1018", in_imem_rvalid, out_imem_addr); end
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rw_discard_valid got=%b exp=0", out_valid); end
        total++; if (out_imem_addr !== 64'h2000 || out_imem_req !== 1'b1) begin bad++; $display("FAIL rw_new_addr got=%h/%b exp=2000/1", out_imem_addr, out_imem_req); end
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        tick(1'b0, 1'b0, 64'd0, 1'b0);
        total++; if (out_pc !== 64'h2000 || out_valid !== 1'b1) begin bad++; $display("FAIL rw_target_pc got=%h/%b exp=2000/1", out_pc, out_valid); end
    endtask

    task automatic test_redirect_stalled();
        mem_lat = 0;
        tick(1'b0, 1'b1, 64'h3000, 1'b1);
        total++; if (out_imem_req !== 1'b0) begin bad++; $display("FAIL rs_req got=%b exp=0", out_imem_req); end
        total++; if (out_pc !== 64'h2000) begin bad++; $display("FAIL rs_hold_pc got=%h exp=2000", out_pc); end
        tick(1'b0, 1'b0, 64'd0, 1'b0);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rs_flush_valid got=%b exp=0", out_valid); end
        total++; if (out_imem_addr !== 64'h3000 || out_imem_req !== 1'b1) begin bad++; $display("FAIL rs_target_addr got=%h/%b exp=3000/1", out_imem_addr, out_imem_req); end
        tick(1'b0, 1'b0, 64'd0, 1'b0);
        total++; if (out_pc !== 64'h3000 || out_inst !== mem_word(64'h3000)) begin bad++; $display("FAIL rs_target_inst got=%h/%h exp=3000/%h", out_pc, out_inst, mem_word(64'h3000)); end
    endtask

    task automatic test_wrap();
        tick(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        total++; if (out_imem_req !== 1'b0) begin bad++; $display("FAIL wrap_redir_req got=%b exp=0", out_imem_req); end
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        total++; if (out_imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_top_addr got=%h exp=fffffffffffffffc", out_imem_addr); end
        tick(1'b1, 1'b0, 64'd0, 1'b0);
        total++; if (out_imem_addr !== 64'd0) begin bad++; $display("FAIL wrap_zero_addr got=%h exp=0", out_imem_addr); end
        total++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_out_pc got=%h exp=fffffffffffffffc", out_pc); end
    endtask

    task automatic test_reset_mid_and_perf();
        @(negedge clk);
        in_rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_imem_req !== 1'b0) begin bad++; $display("FAIL mid_reset got=%b/%b exp=0/0", out_valid, out_imem_req); end
        @(posedge clk); #1;
        in_rst = 1'b0;
        mem_lat = 0;
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 64'd0, 1'b0);
        for (int i = 0; i < 4; i++)  tick(1'b0, 1'b0, 64'd0, 1'b0);
        tick(1'b0, 1'b0, 64'd0, 1'b0);
        total++; if (out_pc !== 64'h1024 || out_valid !== 1'b1) begin bad++; $display("FAIL perf_run_pc got=%h/%b exp=1024/1", out_pc, out_valid); end
`ifdef IF_PERF_EN
        total++; if (out_perf_fetched !== 32'd10) begin bad++; $display("FAIL perf_fetched got=%0d exp=10", out_perf_fetched); end
        total++; if (out_perf_stall !== 32'd4) begin bad++; $display("FAIL perf_stall got=%0d exp=4", out_perf_stall); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_stalled();
        test_wrap();
        test_reset_mid_and_perf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the RV64 core.
- Owns the PC and issues one outstanding request at a time to instruction memory.
- Holds the returned instruction in a one-entry IF/ID output register with a valid/ready handshake to decode.
- Pre-classifies the opcode into the 3-bit immediate-type code that the immediate generator consumes directly.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- in_clk  input  1  clock, rising edge
- in_rst  input  1  reset, asynchronous, active-high
- out_imem_req  output  1  fetch request
- out_imem_addr  output  64  fetch address; stable while out_imem_req is high
- in_imem_rvalid  input  1  response valid; sampled only while out_imem_req is high
- in_imem_rdata  input  32  instruction word, valid with in_imem_rvalid
- in_redirect  input  1  one-cycle redirect (branch/jump/trap)
- in_redirect_pc  input  64  redirect target; bits [1:0] ignored, treated as 0
- out_valid  output  1  IF/ID register holds an instruction
- in_ready  input  1  decode accepts this cycle
- out_inst  output  32  instruction word
- out_pc  output  64  PC of out_inst
- out_inst_type  output  3  0=I, 1=S, 2=B, 3=U, 4=J, 7=none

Behaviour:
- One clock, in_clk. Reset in_rst is asynchronous and active-high.
- Reset values:
  - pc = RESET_PC; state = IDLE.
  - out_imem_req = 0, out_valid = 0.
  - out_inst = 32'h0000_0013 (NOP), out_pc = 0, out_inst_type = 0.
- out_imem_addr = pc at all times, except in DROP, where it holds the address of the abandoned request.
- States:
  - IDLE: no request outstanding. out_imem_req = (!out_valid || in_ready), combinational.
    - If asserted and in_imem_rvalid is high the same cycle: complete, stay IDLE.
    - If asserted without in_imem_rvalid: go to WAIT.
  - WAIT: out_imem_req = 1, address held.
    - On in_imem_rvalid: complete and go to IDLE.
    - Because requests start only when the IF/ID register is empty or draining, the register is always empty when the response arrives.
  - DROP: out_imem_req = 1 with the old address held. On in_imem_rvalid: discard the data and go to IDLE.
- Complete means, registered:
  - out_inst <= in_imem_rdata, out_pc <= pc, out_inst_type <= decoded type.
  - out_valid <= 1, pc <= pc + 4 (64-bit wrap, FFFF_FFFF_FFFF_FFFC -> 0).
- Handshake:
  - out_valid drops when in_ready is high and no completion happens that cycle.
  - out_inst, out_pc and out_inst_type are stable while out_valid && !in_ready.
  - Throughput: 1 instruction/cycle with zero-latency memory and in_ready held high.
- Redirect has highest priority:
  - pc <= {in_redirect_pc[63:2], 2'b00}; out_valid <= 0 (flush), regardless of in_ready.
  - In WAIT without in_imem_rvalid that cycle: go to DROP.
  - In WAIT with in_imem_rvalid the same cycle: the response is discarded; go to IDLE.
  - In DROP: pc is updated; stay DROP.
  - In IDLE: no request is issued that cycle; the new pc is fetched the next cycle.
- Type decode from opcode in_imem_rdata[6:0]:
  - 0000011, 0010011, 0011011, 1100111 -> 0
  - 0100011 -> 1
  - 1100011 -> 2
  - 0110111, 0010111 -> 3
  - 1101111 -> 4
  - anything else -> 7
- Reset asserted mid-request: all state clears immediately. The memory must abandon the request when out_imem_req falls.

Optional Feature:
- Macro: IF_PERF_EN.
- Defined: adds two outputs.
  - out_perf_fetched [31:0]: counts completions.
  - out_perf_stall [31:0]: counts cycles with out_valid && !in_ready.
  - Both counters reset to 0, saturate at 32'hFFFF_FFFF, and are not cleared by redirect.
- Undefined: ports and logic are absent.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants: OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL;
  - inst-type codes: IT_I=0, IT_S=1, IT_B=2, IT_U=3, IT_J=4, IT_NONE=7;
  - NOP_INST = 32'h0000_0013.
- One natural sub-module: inst_type_dec, the combinational opcode -> type decoder.

Test Plan:
- Reset, RESET_PC=64'h1000, zero-latency memory, in_ready=1 -> addrs 1000, 1004, 1008 on consecutive cycles; out_pc follows one cycle later; out_valid stays 1.
- Memory returns 32'h0000_0537 (LUI) then 32'h0000_006F (JAL) then 32'h0000_0033 (R-type) -> out_inst_type = 3, 4, 7.
- 3-cycle memory latency, in_ready=0 for 5 cycles after the first completion -> out_inst/out_pc held stable; no request while stalled; out_imem_req rises in the cycle in_ready returns.
- Redirect to 64'h2003 during WAIT -> state DROP; old response discarded; out_valid=0; next request address 64'h2000.
- Redirect in the same cycle as in_imem_rvalid and with out_valid=1, in_ready=0 -> response dropped; out_valid=0 next cycle; next fetch at the redirect target.
- pc = 64'hFFFF_FFFF_FFFF_FFFC completes -> next address 0. With IF_PERF_EN, after 10 completions and 4 stall cycles -> out_perf_fetched=10, out_perf_stall=4.
